test017_switch_fields: RTL and testbench

Method-call block exposing four 32-bit public field registers (`test0`..`test3`) and one method, `test(idx)`. The method uses `idx` to select a field, writes a case-specific constant into it, then returns whether the field now holds that constant. It sits behind the standard req/busy/return method handshake used by generated method blocks, and is driven by a host FSM or a testbench.

---
 rtl/test017_pkg.sv | 29 ++
 rtl/field_reg32.sv | 36 +++
 rtl/test017_switch_fields.sv | 129 ++++++++++++
 tb/tb_test017_switch_fields.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/test017_pkg.sv
// rtl/test017_pkg.sv - shared types and constants for the switch-fields method block
package test017_pkg;

  localparam int NUM_FIELDS = 4;

  localparam logic [31:0] C0 = 32'd100;
  localparam logic [31:0] C1 = 32'd200;
  localparam logic [31:0] C2 = 32'd300;
  localparam logic [31:0] C3 = 32'd400;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_WRITE   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Constant the method writes into the field chosen by sel.
  function automatic logic [31:0] case_const(input logic [1:0] sel);
    case (sel)
      2'd0:    case_const = C0;
      2'd1:    case_const = C1;
      2'd2:    case_const = C2;
      default: case_const = C3;
    endcase
  endfunction

endpackage

// File: rtl/field_reg32.sv
// rtl/field_reg32.sv - 32-bit field register with external write and priority method write
module field_reg32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_we,
  input  logic [31:0] ext_in,
  input  logic        m_we,
  input  logic [31:0] m_data,
  output logic [31:0] value_o
);

  logic [31:0] value_q;
  logic [31:0] value_d;

  // Method write overrides a same-cycle external write.
  always_comb begin
    value_d = value_q;
    if (m_we) begin
      value_d = m_data;
    end else if (ext_we) begin
      value_d = ext_in;
    end
  end

  // Field storage, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/test017_switch_fields.sv
// rtl/test017_switch_fields.sv - four public fields plus the test(idx) method FSM
module test017_switch_fields
  import test017_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] test0_in,
  input  logic        test0_we,
  output logic [31:0] test0_out,
  input  logic [31:0] test1_in,
  input  logic        test1_we,
  output logic [31:0] test1_out,
  input  logic [31:0] test2_in,
  input  logic        test2_we,
  output logic [31:0] test2_out,
  input  logic [31:0] test3_in,
  input  logic        test3_we,
  output logic [31:0] test3_out,
  input  logic [31:0] test_idx,
  input  logic        test_req,
  output logic        test_busy,
  output logic        test_return
);

  state_t      state_q, state_d;
  logic [31:0] idx_q, idx_d;
  logic [1:0]  sel_q, sel_d;
  logic        valid_q, valid_d;
  logic        cmp_q, cmp_d;
  logic        ret_q, ret_d;

  logic [31:0] ext_in   [NUM_FIELDS];
  logic        ext_we   [NUM_FIELDS];
  logic [31:0] field_val[NUM_FIELDS];
  logic        m_we     [NUM_FIELDS];
  logic [31:0] m_data;

  assign ext_in[0] = test0_in;
  assign ext_in[1] = test1_in;
  assign ext_in[2] = test2_in;
  assign ext_in[3] = test3_in;
  assign ext_we[0] = test0_we;
  assign ext_we[1] = test1_we;
  assign ext_we[2] = test2_we;
  assign ext_we[3] = test3_we;

  assign m_data = case_const(sel_q);

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    assign m_we[k] = (state_q == ST_WRITE) && valid_q && (sel_q == k[1:0]);

    field_reg32 u_field (
      .clk     (clk),
      .reset   (reset),
      .ext_we  (ext_we[k]),
      .ext_in  (ext_in[k]),
      .m_we    (m_we[k]),
      .m_data  (m_data),
      .value_o (field_val[k])
    );
  end

  assign test0_out = field_val[0];
  assign test1_out = field_val[1];
  assign test2_out = field_val[2];
  assign test3_out = field_val[3];

  // State and datapath registers; reset abandons any call in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      cmp_q   <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      cmp_q   <= cmp_d;
      ret_q   <= ret_d;
    end
  end

  // Next-state sequencing and per-state datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    cmp_d   = cmp_q;
    ret_d   = ret_q;
    case (state_q)
      ST_IDLE: begin
        if (test_req) begin
          idx_d   = test_idx;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Negative indices have bit 31 set, so one upper-bits test covers both ranges.
        sel_d   = idx_q[1:0];
        valid_d = (idx_q[31:2] == 30'd0);
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        cmp_d   = valid_q && (field_val[sel_q] == case_const(sel_q));
        state_d = ST_DONE;
      end
      ST_DONE: begin
        ret_d   = cmp_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs: busy for every non-idle state, return held between calls.
  always_comb begin
    test_busy   = (state_q != ST_IDLE);
    test_return = ret_q;
  end

endmodule

// File: tb/tb_test017_switch_fields.sv
// tb/tb_test017_switch_fields.sv - directed self-checking bench for test017_switch_fields
module tb_test017_switch_fields;

  logic        clk;
  logic        reset;
  logic [31:0] test0_in, test1_in, test2_in, test3_in;
  logic        test0_we, test1_we, test2_we, test3_we;
  logic [31:0] test0_out, test1_out, test2_out, test3_out;
  logic [31:0] test_idx;
  logic        test_req;
  logic        test_busy;
  logic        test_return;

  int errors;
  int checks;

  test017_switch_fields dut (
    .clk         (clk),
    .reset       (reset),
    .test0_in    (test0_in),
    .test0_we    (test0_we),
    .test0_out   (test0_out),
    .test1_in    (test1_in),
    .test1_we    (test1_we),
    .test1_out   (test1_out),
    .test2_in    (test2_in),
    .test2_we    (test2_we),
    .test2_out   (test2_out),
    .test3_in    (test3_in),
    .test3_we    (test3_we),
    .test3_out   (test3_out),
    .test_idx    (test_idx),
    .test_req    (test_req),
    .test_busy   (test_busy),
    .test_return (test_return)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one call; returns the number of sampled busy cycles.
  task automatic do_call(input logic [31:0] idx, output int busy_cycles);
    test_idx = idx;
    test_req = 1'b1;
    step();
    test_req = 1'b0;
    test_idx = 32'hFFFF_FFF0;
    busy_cycles = 0;
    while (test_busy && busy_cycles < 20) begin
      busy_cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    checks++;
    if ({test0_out, test1_out, test2_out, test3_out} !== 128'd0) begin
      errors++;
      $display("FAIL reset_fields got %h %h %h %h want all 0", test0_out, test1_out, test2_out, test3_out);
    end
    checks++;
    if (test_busy !== 1'b0 || test_return !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake got busy=%b ret=%b want 0 0", test_busy, test_return);
    end
  endtask

  task automatic test_idx3();
    int bc;
    do_call(32'd3, bc);
    checks++;
    if (bc != 4) begin
      errors++;
      $display("FAIL idx3_latency got %0d want 4", bc);
    end
    checks++;
    if (test3_out !== 32'd400 || test_return !== 1'b1) begin
      errors++;
      $display("FAIL idx3_result got f3=%0d ret=%b want 400 1", test3_out, test_return);
    end
    checks++;
    if ({test0_out, test1_out, test2_out} !== 96'd0) begin
      errors++;
      $display("FAIL idx3_others got %h %h %h want 0 0 0", test0_out, test1_out, test2_out);
    end
  endtask

  task automatic test_idx_loop();
    int bc;
    logic [31:0] exp_val [3];
    logic [31:0] got;
    exp_val[0] = 32'd100;
    exp_val[1] = 32'd200;
    exp_val[2] = 32'd300;
    for (int i = 0; i < 3; i++) begin
      do_call(i, bc);
      got = (i == 0) ? test0_out : (i == 1) ? test1_out : test2_out;
      checks++;
      if (got !== exp_val[i] || test_return !== 1'b1 || bc != 4) begin
        errors++;
        $display("FAIL idx%0d_call got val=%0d ret=%b busy=%0d want %0d 1 4", i, got, test_return, bc, exp_val[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    int bc;
    logic [31:0] bad [2];
    bad[0] = 32'd7;
    bad[1] = 32'hFFFF_FFFF;
    test0_we = 1'b1; test0_in = 32'hA5A5_0000;
    test1_we = 1'b1; test1_in = 32'hA5A5_0001;
    test2_we = 1'b1; test2_in = 32'hA5A5_0002;
    test3_we = 1'b1; test3_in = 32'hA5A5_0003;
    step();
    test0_we = 1'b0; test1_we = 1'b0; test2_we = 1'b0; test3_we = 1'b0;
    checks++;
    if (test0_out !== 32'hA5A5_0000 || test3_out !== 32'hA5A5_0003) begin
      errors++;
      $display("FAIL ext_write got %h %h want a5a50000 a5a50003", test0_out, test3_out);
    end
    // Make the previous return 1 so a 0 from the bad call is a real update.
    do_call(32'd1, bc);
    for (int i = 0; i < 2; i++) begin
      do_call(bad[i], bc);
      checks++;
      if (test_return !== 1'b0 || bc != 4) begin
        errors++;
        $display("FAIL oor%0d_ret got ret=%b busy=%0d want 0 4", i, test_return, bc);
      end
      checks++;
      if (test0_out !== 32'hA5A5_0000 || test1_out !== 32'd200 ||
          test2_out !== 32'hA5A5_0002 || test3_out !== 32'hA5A5_0003) begin
        errors++;
        $display("FAIL oor%0d_fields got %h %h %h %h want a5a50000 000000c8 a5a50002 a5a50003",
                 i, test0_out, test1_out, test2_out, test3_out);
      end
    end
  endtask

  task automatic test_write_collision();
    int bc;
    test_idx = 32'd3;
    test_req = 1'b1;
    step();                 // accepted (edge N)
    test_req = 1'b0;
    test_idx = 32'd0;
    step();                 // edge N+1, now in WRITE
    test3_we = 1'b1;
    test3_in = 32'hDEAD_BEEF;
    step();                 // edge N+2: both writes land
    test3_we = 1'b0;
    checks++;
    if (test3_out !== 32'd400) begin
      errors++;
      $display("FAIL collision_field got %h want 00000190", test3_out);
    end
    bc = 0;
    while (test_busy && bc < 20) begin
      bc++;
      step();
    end
    checks++;
    if (test_return !== 1'b1 || bc != 2) begin
      errors++;
      $display("FAIL collision_ret got ret=%b tail=%0d want 1 2", test_return, bc);
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    int wait_cnt;
    test_idx = 32'd3;
    test_req = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      bc = 0;
      while (test_busy && bc < 20) begin
        bc++;
        step();
      end
      checks++;
      if (bc != 4 || test_return !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d_call got busy=%0d ret=%b want 4 1", c, bc, test_return);
      end
      wait_cnt = 0;
      while (!test_busy && wait_cnt < 20) begin
        wait_cnt++;
        step();
      end
      checks++;
      if (wait_cnt != 1) begin
        errors++;
        $display("FAIL b2b%0d_gap got %0d want 1", c, wait_cnt);
      end
    end
    step();                 // mid-call of the next invocation
    reset = 1'b0;
    #1;
    checks++;
    if (test_busy !== 1'b0 || test_return !== 1'b0 ||
        {test0_out, test1_out, test2_out, test3_out} !== 128'd0) begin
      errors++;
      $display("FAIL midcall_reset got busy=%b ret=%b f=%h %h %h %h want all 0",
               test_busy, test_return, test0_out, test1_out, test2_out, test3_out);
    end
    test_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    checks++;
    if (test_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b want 0", test_busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    test0_in = '0; test1_in = '0; test2_in = '0; test3_in = '0;
    test0_we = 1'b0; test1_we = 1'b0; test2_we = 1'b0; test3_we = 1'b0;
    test_idx = '0;
    test_req = 1'b0;
    #2;
    test_reset();
    test_idx3();
    test_idx_loop();
    test_out_of_range();
    test_write_collision();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
